// File: rtl/brownout_seq_pkg.sv
// Shared types and default widths for the brownout reset sequencer.
// State encoding is fixed because it is exported on the state port.
package brownout_seq_pkg;

    localparam int DEB_W_DEF  = 4;
    localparam int HOLD_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        BO_DISABLED = 2'd0,
        BO_ARMED    = 2'd1,
        BO_ASSERT   = 2'd2,
        BO_HOLD     = 2'd3
    } bo_state_e;

endpackage

// File: rtl/brownout_sync.sv
// Two-flop synchronizer for an asynchronous comparator output.
// Clears to 0 on reset so no fault is seen until real samples arrive.
module brownout_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/brownout_rst_seq.sv
// Brownout/undervoltage reset sequencer: debounce, assert, timed hold.
// Keeps sticky cause flags and a saturating count of fault entries.
module brownout_rst_seq
    import brownout_seq_pkg::*;
#(
    parameter int DEB_W  = DEB_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              osc_ck,
    input  logic              rst,
    input  logic              ena,
    input  logic              brout,
    input  logic              vunder,
    input  logic [DEB_W-1:0]  deb_cfg,
    input  logic [HOLD_W-1:0] hold_cfg,
    input  logic              clr_flags,
    output logic              rst_out,
    output logic              brout_flag,
    output logic              vunder_flag,
    output logic [CNT_W-1:0]  event_cnt,
    output logic [1:0]        state
);

    localparam logic [1:0] S_DIS  = BO_DISABLED;
    localparam logic [1:0] S_ARM  = BO_ARMED;
    localparam logic [1:0] S_ASRT = BO_ASSERT;
    localparam logic [1:0] S_HOLD = BO_HOLD;

    logic brout_s;
    logic vunder_s;
    logic fault_s;
    logic qual;
    logic enter_asrt;

    logic [1:0]        state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  evt_q, evt_d;
    logic              rst_out_q, rst_out_d;
    logic              bflag_q, bflag_d;
    logic              vflag_q, vflag_d;

    brownout_sync u_sync_brout (
        .clk_i (osc_ck),
        .rst_i (rst),
        .d_i   (brout),
        .q_o   (brout_s)
    );

    brownout_sync u_sync_vunder (
        .clk_i (osc_ck),
        .rst_i (rst),
        .d_i   (vunder),
        .q_o   (vunder_s)
    );

    assign fault_s = brout_s | vunder_s;
    assign qual    = fault_s && (deb_q == deb_cfg);

    // Debounce saturates so a long fault cannot wrap into a false match.
    always_comb begin
        deb_d = deb_q;
        if (!ena || state_q == S_DIS || !fault_s) begin
            deb_d = '0;
        end else if (deb_q != '1) begin
            deb_d = deb_q + DEB_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (!ena) begin
            state_d = S_DIS;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                S_DIS: begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end
                S_ARM: begin
                    if (qual) begin
                        state_d = S_ASRT;
                    end
                end
                S_ASRT: begin
                    if (!fault_s) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end
                end
                S_HOLD: begin
                    if (qual) begin
                        state_d = S_ASRT;
                        hold_d  = '0;
                    end else if (hold_q == hold_cfg) begin
                        state_d = S_ARM;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign enter_asrt = (state_d == S_ASRT) && (state_q != S_ASRT);
    assign rst_out_d  = (state_d == S_ASRT) || (state_d == S_HOLD);

    // A coincident entry beats clr_flags: flags set, count restarts at 1.
    always_comb begin
        bflag_d = bflag_q & ~clr_flags;
        vflag_d = vflag_q & ~clr_flags;
        evt_d   = clr_flags ? '0 : evt_q;
        if (enter_asrt) begin
            if (brout_s) begin
                bflag_d = 1'b1;
            end
            if (vunder_s) begin
                vflag_d = 1'b1;
            end
            if (clr_flags) begin
                evt_d = CNT_W'(1);
            end else if (evt_q != '1) begin
                evt_d = evt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            state_q   <= S_HOLD;
            deb_q     <= '0;
            hold_q    <= '0;
            evt_q     <= '0;
            rst_out_q <= 1'b1;
            bflag_q   <= 1'b0;
            vflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            evt_q     <= evt_d;
            rst_out_q <= rst_out_d;
            bflag_q   <= bflag_d;
            vflag_q   <= vflag_d;
        end
    end

    assign rst_out     = rst_out_q;
    assign brout_flag  = bflag_q;
    assign vunder_flag = vflag_q;
    assign event_cnt   = evt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_brownout_rst_seq.sv
// Directed bench for brownout_rst_seq with hand-derived expectations.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_brownout_rst_seq;

    localparam int DEB_W  = 4;
    localparam int HOLD_W = 8;
    localparam int CNT_W  = 2;

    logic              osc_ck;
    logic              rst;
    logic              ena;
    logic              brout;
    logic              vunder;
    logic [DEB_W-1:0]  deb_cfg;
    logic [HOLD_W-1:0] hold_cfg;
    logic              clr_flags;
    logic              rst_out;
    logic              brout_flag;
    logic              vunder_flag;
    logic [CNT_W-1:0]  event_cnt;
    logic [1:0]        state;

    int n_chk;
    int n_err;

    brownout_rst_seq #(
        .DEB_W  (DEB_W),
        .HOLD_W (HOLD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .osc_ck      (osc_ck),
        .rst         (rst),
        .ena         (ena),
        .brout       (brout),
        .vunder      (vunder),
        .deb_cfg     (deb_cfg),
        .hold_cfg    (hold_cfg),
        .clr_flags   (clr_flags),
        .rst_out     (rst_out),
        .brout_flag  (brout_flag),
        .vunder_flag (vunder_flag),
        .event_cnt   (event_cnt),
        .state       (state)
    );

    initial osc_ck = 1'b0;
    always #5 osc_ck = ~osc_ck;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge osc_ck);
            #1;
        end
    endtask

    // One brout fault with deb_cfg=0, hold_cfg=2: 3 edges to ASSERT,
    // then 3 edges to HOLD and 3 HOLD edges back to ARMED.
    task automatic fault_event();
        brout = 1'b1;
        tick(3);
        brout = 1'b0;
        tick(6);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        ena       = 1'b1;
        brout     = 1'b0;
        vunder    = 1'b0;
        deb_cfg   = '0;
        hold_cfg  = 8'd4;
        clr_flags = 1'b0;

        #2;
        chk("rst_state", 32'(state), 32'd3);
        chk("rst_rstout", 32'(rst_out), 32'd1);
        chk("rst_evt", 32'(event_cnt), 32'd0);
        chk("rst_flags", 32'({brout_flag, vunder_flag}), 32'd0);

        // Release: hold_cfg=4 gives 5 HOLD edges
        tick(1);
        rst = 1'b0;
        tick(4);
        chk("rel_hold4", 32'(rst_out), 32'd1);
        tick(1);
        chk("rel_rstout", 32'(rst_out), 32'd0);
        chk("rel_state", 32'(state), 32'd1);

        // Short brout pulse, deb_cfg=3: never qualifies
        deb_cfg = 4'd3;
        brout = 1'b1;
        tick(3);
        brout = 1'b0;
        tick(5);
        chk("short_state", 32'(state), 32'd1);
        chk("short_evt", 32'(event_cnt), 32'd0);
        chk("short_rstout", 32'(rst_out), 32'd0);

        // Long pulse: rst_out rises on the 6th edge
        brout = 1'b1;
        tick(5);
        chk("long_e5", 32'(rst_out), 32'd0);
        tick(1);
        chk("long_e6", 32'(rst_out), 32'd1);
        chk("long_state", 32'(state), 32'd2);
        chk("long_bflag", 32'(brout_flag), 32'd1);
        chk("long_vflag", 32'(vunder_flag), 32'd0);
        chk("long_evt", 32'(event_cnt), 32'd1);

        // Hand fault over to vunder without a gap
        brout  = 1'b0;
        vunder = 1'b1;
        tick(4);
        chk("handoff_state", 32'(state), 32'd2);
        chk("handoff_vflag", 32'(vunder_flag), 32'd0);

        // vunder falls, HOLD, re-fault at HOLD count 5
        deb_cfg  = 4'd0;
        hold_cfg = 8'd10;
        vunder   = 1'b0;
        tick(3);
        chk("hold_entry", 32'(state), 32'd3);
        chk("hold_rstout", 32'(rst_out), 32'd1);
        tick(4);
        vunder = 1'b1;
        tick(2);
        chk("refault_e2", 32'(state), 32'd3);
        tick(1);
        chk("refault_state", 32'(state), 32'd2);
        chk("refault_evt", 32'(event_cnt), 32'd2);
        chk("refault_vflag", 32'(vunder_flag), 32'd1);

        // Final clear: full 11-edge hold
        vunder = 1'b0;
        tick(3);
        chk("hold2_entry", 32'(state), 32'd3);
        tick(10);
        chk("hold2_e11m1", 32'(rst_out), 32'd1);
        tick(1);
        chk("hold2_state", 32'(state), 32'd1);
        chk("hold2_rstout", 32'(rst_out), 32'd0);

        // ena drop in ASSERT
        brout = 1'b1;
        tick(3);
        chk("ena_asrt", 32'(state), 32'd2);
        chk("ena_sat", 32'(event_cnt), 32'd3);
        ena = 1'b0;
        tick(1);
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_rstout", 32'(rst_out), 32'd0);
        chk("dis_flags", 32'({brout_flag, vunder_flag}), 32'd3);
        chk("dis_evt", 32'(event_cnt), 32'd3);
        brout = 1'b0;
        hold_cfg = 8'd2;
        tick(3);
        chk("dis_stay", 32'(state), 32'd0);
        ena = 1'b1;
        tick(1);
        chk("en_hold", 32'(state), 32'd3);
        chk("en_rstout", 32'(rst_out), 32'd1);
        tick(2);
        chk("en_hold_e3", 32'(state), 32'd3);
        tick(1);
        chk("en_armed", 32'(state), 32'd1);

        // Five entries total with CNT_W=2 -> saturate at 3
        fault_event();
        fault_event();
        chk("sat_evt", 32'(event_cnt), 32'd3);
        chk("sat_state", 32'(state), 32'd1);

        // clr_flags coincident with the 6th entry
        brout = 1'b1;
        tick(2);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        chk("clrwin_state", 32'(state), 32'd2);
        chk("clrwin_evt", 32'(event_cnt), 32'd1);
        chk("clrwin_bflag", 32'(brout_flag), 32'd1);
        chk("clrwin_vflag", 32'(vunder_flag), 32'd0);
        brout = 1'b0;
        tick(6);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        chk("clr_evt", 32'(event_cnt), 32'd0);
        chk("clr_flags", 32'({brout_flag, vunder_flag}), 32'd0);

        // Async reset mid-HOLD
        vunder = 1'b1;
        tick(3);
        vunder = 1'b0;
        tick(3);
        chk("pre_rst_state", 32'(state), 32'd3);
        chk("pre_rst_vflag", 32'(vunder_flag), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rstout", 32'(rst_out), 32'd1);
        chk("arst_vflag", 32'(vunder_flag), 32'd0);
        chk("arst_evt", 32'(event_cnt), 32'd0);
        chk("arst_state", 32'(state), 32'd3);

        // Release with ena=0 -> DISABLED on first edge
        ena = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("rel_dis_state", 32'(state), 32'd0);
        chk("rel_dis_rstout", 32'(rst_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/brownout_rst_seq.md
BROWNOUT_RST_SEQ -- requirements
Module: brownout_rst_seq

Interface
REQ-001 Parameter DEB_W, default 4: width of debounce configuration and counter.
REQ-002 Parameter HOLD_W, default 8: width of reset-hold configuration and counter.
REQ-003 Parameter CNT_W, default 8: width of saturating fault-event counter.
REQ-004 osc_ck  in  1  single clock, rising-edge; all state in this domain.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ena  in  1  sequencer enable (synchronous level).
REQ-007 brout  in  1  brownout comparator output, asynchronous to osc_ck.
REQ-008 vunder  in  1  undervoltage comparator output, asynchronous to osc_ck.
REQ-009 deb_cfg  in  DEB_W  debounce length; fault qualified after deb_cfg+1 consecutive synchronized-high cycles.
REQ-010 hold_cfg  in  HOLD_W  hold length; reset released after hold_cfg+1 HOLD cycles.
REQ-011 clr_flags  in  1  single-cycle clear of sticky flags and event counter.
REQ-012 rst_out  out  1  system reset request, active-high, registered.
REQ-013 brout_flag  out  1  sticky: brownout caused a fault entry.
REQ-014 vunder_flag  out  1  sticky: undervoltage caused a fault entry.
REQ-015 event_cnt  out  CNT_W  count of fault entries, saturating.
REQ-016 state  out  2  current FSM state encoding.

Function
REQ-017 brout and vunder SHALL each pass a 2-flop synchronizer before any use; fault_s = brout_s OR vunder_s.
REQ-018 Debounce counter SHALL increment while fault_s=1 and clear when fault_s=0; fault qualified when fault_s=1 and count equals deb_cfg.
REQ-019 FSM states SHALL be DISABLED(0), ARMED(1), ASSERT(2), HOLD(3).
REQ-020 ARMED -> ASSERT on qualified fault; rst_out rises on that edge.
REQ-021 With deb_cfg=0, rst_out SHALL rise on the 3rd rising edge that samples brout or vunder high; each deb_cfg increment adds one edge.
REQ-022 ASSERT -> HOLD on the first edge where fault_s=0; hold counter loads 0; rst_out stays 1.
REQ-023 HOLD increments hold counter each cycle; HOLD -> ARMED on the edge where counter equals hold_cfg; rst_out falls on that edge.
REQ-024 Qualified fault during HOLD SHALL return to ASSERT and clear the hold counter.
REQ-025 ena=0 SHALL force DISABLED on the next edge from any state; DISABLED drives rst_out=0 and clears debounce and hold counters; flags and event_cnt retained.
REQ-026 DISABLED -> HOLD when ena=1 (hold counter 0, rst_out=1).
REQ-027 event_cnt SHALL increment on every entry to ASSERT and saturate at 2^CNT_W-1.
REQ-028 On ASSERT entry, brout_flag set if brout_s=1, vunder_flag set if vunder_s=1.
REQ-029 clr_flags clears flags and event_cnt; a simultaneous set/increment SHALL win (flag=1, event_cnt=1).
REQ-030 hold_cfg and deb_cfg SHALL be sampled live each cycle; a change mid-count applies to the ongoing comparison.

Reset
REQ-031 rst=1 SHALL immediately force state=HOLD, rst_out=1, all counters, synchronizers, flags and event_cnt=0.
REQ-032 After rst release, HOLD timing per REQ-023 applies, or REQ-025 if ena=0.

Structure
REQ-033 Package brownout_seq_pkg SHALL hold the state enum and default width constants.
REQ-034 Sub-module brownout_sync (2-flop synchronizer, async-reset to 0) SHALL be instantiated once per comparator input.

Verification
REQ-035 Reset release, ena=1, hold_cfg=4 -> rst_out low 5 cycles after release, state=ARMED.
REQ-036 ARMED, deb_cfg=3, brout pulse 3 cycles -> no ASSERT, event_cnt=0; pulse 6 cycles -> rst_out rises 6th edge, brout_flag=1, event_cnt=1.
REQ-037 ASSERT, vunder falls, hold_cfg=10, fault reasserts at HOLD cycle 5 -> ASSERT re-entered, event_cnt+1, full 11-cycle hold after final clear.
REQ-038 ena dropped in ASSERT -> DISABLED next edge, rst_out=0, flags kept; ena=1 -> HOLD then ARMED.
REQ-039 CNT_W=2, 5 fault events -> event_cnt=3; clr_flags coincident with 6th entry -> event_cnt=1.
REQ-040 rst asserted mid-HOLD asynchronously -> rst_out=1 and flags=0 without a clock edge.
